signed_bcd_converter: RTL

Sequential converter placed directly downstream of the 8-bit two's-complement negation stage. Takes an 8-bit two's-complement result and produces a sign flag plus three BCD digits (hundreds/tens/ones) for the seven-segment display driver. It uses iterative double-dabble, one shift per clock, with a start/busy/done handshake.

---
 rtl/signed_bcd_converter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/signed_bcd_converter.sv
// Signed binary-to-BCD converter for the seven-segment display path.
// Takes an 8-bit two's-complement value and produces a sign flag plus
// hundreds/tens/ones BCD digits. It uses iterative double-dabble with one
// shift per clock and a start/busy/done handshake.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     conversion request, sampled only while idle
//   value     two's-complement operand (-128..127)
//   busy      high while shifting
//   done      one-cycle pulse when neg/digits are updated
//   neg       operand was negative
//   hundreds  BCD hundreds digit (0..1)
//   tens      BCD tens digit (0..9)
//   ones      BCD ones digit (0..9)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; done may be high for one cycle here
// SHIFT | 8 add-3/shift iterations, count_q = 0..7

module signed_bcd_converter (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] value,
   output logic       busy,
   output logic       done,
   output logic       neg,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        sign_q, sign_d;
   logic [7:0]  mag_q, mag_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  count_q, count_d;
   logic        done_q, done_d;
   logic        neg_q, neg_d;
   logic [3:0]  hund_q, hund_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;

   logic [11:0] bcd_adj;
   logic [11:0] bcd_sh;
   logic [7:0]  mag_sh;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Correct every nibble before the shift so that the doubling carries
   // into the next decade. The hundreds digit never reaches 5 for |v|<=128.
   always_comb begin
      bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      bcd_sh  = {bcd_adj[10:0], mag_q[7]};
      mag_sh  = {mag_q[6:0], 1'b0};
   end

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      done_d  = 1'b0;
      neg_d   = neg_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d  = value[7];
               // -128 negates to 0x80, which reads as 128 when unsigned.
               mag_d   = value[7] ? (~value + 8'd1) : value;
               bcd_d   = 12'd0;
               count_d = 3'd0;
               state_d = SHIFT;
            end
         end
         default: begin
            bcd_d   = bcd_sh;
            mag_d   = mag_sh;
            count_d = count_q + 3'd1;
            if (count_q == 3'd7) begin
               hund_d  = bcd_sh[11:8];
               tens_d  = bcd_sh[7:4];
               ones_d  = bcd_sh[3:0];
               neg_d   = sign_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= 8'd0;
         bcd_q   <= 12'd0;
         count_q <= 3'd0;
         done_q  <= 1'b0;
         neg_q   <= 1'b0;
         hund_q  <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
         done_q  <= done_d;
         neg_q   <= neg_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign neg      = neg_q;
   assign hundreds = hund_q;
   assign tens     = tens_q;
   assign ones     = ones_q;

endmodule
